wb_nop_master: RTL and testbench

//  Minimal Wishbone classic master issuing empty "no-operation" bus cycles: no address, data or WE.

---
 rtl/wb_nop_pkg.sv | 19 +
 rtl/wb_nop_timeout_ctr.sv | 39 +++
 rtl/wb_nop_master.sv | 118 +++++++++++
 tb/tb_wb_nop_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/wb_nop_pkg.sv
// Shared definitions for the Wishbone NOP master.
//   state_t          FSM encoding (IDLE, BUS, DONE)
//   TIMEOUT_CYC_DEF  default ACK wait limit in clocks
//   cnt_width()      bits needed to count 0..n-1 (minimum 1)
package wb_nop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_nop_timeout_ctr.sv
// ACK wait counter for the NOP master.
//   clk_i      system clock
//   rst_i      asynchronous active-low reset
//   clr_i      hold count at zero (asserted outside the bus phase)
//   en_i       count one bus clock without ACK
//   expired_o  high during the last permitted bus clock (count == CYC-1)
module wb_nop_timeout_ctr
  import wb_nop_pkg::*;
#(
  parameter int unsigned CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned     W    = cnt_width(CYC);
  localparam logic [W-1:0]    LAST = W'((CYC > 0) ? CYC - 1 : 0);

  logic [W-1:0] r_cnt;
  logic         w_expired;

  assign w_expired = (r_cnt >= LAST);
  assign expired_o = w_expired;

  // Count stops at LAST so it never wraps back below the limit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_nop_master.sv
// Minimal Wishbone classic master issuing empty (no address/data/WE) cycles.
// Each trigger starts one CYC/STB phase that the slave closes with ACK.
//   clk_i      system clock (rising edge)
//   rst_i      asynchronous active-low reset
//   cyc_o      Wishbone CYC
//   stb_o      Wishbone STB
//   ack_i      Wishbone ACK from slave
//   trigger_i  level request to start a NOP cycle
//   busy_o     cycle in progress (same as cyc_o)
//   done_o     one-clock pulse after an ACK-terminated cycle
//   txn_cnt_o  ACK-terminated cycles since reset, wraps
//   timeout_o  one-clock pulse on ACK timeout abort
// Build option: define WB_NOP_TIMEOUT_EN to abort a cycle after TIMEOUT_CYC
// clocks without ACK; otherwise the bus phase waits indefinitely and
// timeout_o is constant 0.
module wb_nop_master
  import wb_nop_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic             ack_i,
  input  logic             trigger_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] txn_cnt_o,
  output logic             timeout_o
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_complete;
  logic               w_cyc_nxt;
  logic               r_cyc;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;

`ifdef WB_NOP_TIMEOUT_EN
  logic w_expired;
  logic w_abort;
  logic r_tmo;

  wb_nop_timeout_ctr #(
    .CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (r_state != ST_BUS),
    .en_i      (r_state == ST_BUS),
    .expired_o (w_expired)
  );

  // ACK on the expiry edge takes priority over the abort.
  assign w_abort = (r_state == ST_BUS) && !ack_i && w_expired;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_tmo <= 1'b0;
    else        r_tmo <= w_abort;
  end

  assign timeout_o = r_tmo;
`else
  localparam int unsigned P_UNUSED_TMO = TIMEOUT_CYC;
  assign timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (trigger_i) w_state_nxt = ST_BUS;
      ST_BUS: begin
        if (ack_i) w_state_nxt = ST_DONE;
`ifdef WB_NOP_TIMEOUT_EN
        else if (w_expired) w_state_nxt = ST_DONE;
`endif
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next-cycle values, registered below so no input
  // reaches an output combinationally.
  always_comb begin
    w_complete = (r_state == ST_BUS) && ack_i;
    w_cyc_nxt  = (w_state_nxt == ST_BUS);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cyc  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_cyc  <= w_cyc_nxt;
      r_done <= w_complete;
      if (w_complete) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;
  assign busy_o    = r_cyc;
  assign done_o    = r_done;
  assign txn_cnt_o = r_cnt;

endmodule

// File: tb/tb_wb_nop_master.sv
module tb_wb_nop_master;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             trig = 1'b0;
  logic             ack = 1'b0;
  logic             cyc, stb, busy, done, tmo;
  logic [CNT_W-1:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_nop_master #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cyc_o     (cyc),
    .stb_o     (stb),
    .ack_i     (ack),
    .trigger_i (trig),
    .busy_o    (busy),
    .done_o    (done),
    .txn_cnt_o (cnt),
    .timeout_o (tmo)
  );

  typedef struct {
    logic             rst;
    logic             trig;
    logic             ack;
    logic             cyc;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic a);
    @(negedge clk);
    rst = r; trig = t; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_cyc, input logic e_done,
                            input logic [CNT_W-1:0] e_cnt, input logic e_tmo);
    check({tag, ".cyc"},  {31'd0, cyc},  {31'd0, e_cyc});
    check({tag, ".stb"},  {31'd0, stb},  {31'd0, e_cyc});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_cyc});
    check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    check({tag, ".cnt"},  32'(cnt),      32'(e_cnt));
    check({tag, ".tmo"},  {31'd0, tmo},  {31'd0, e_tmo});
  endtask

  initial begin
    // rst trig ack | cyc done cnt  (expected after the edge)
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};  // reset holds, trigger ignored
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};  // IDLE->BUS
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};  // ACK 3 clks after STB
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};  // spurious ACK x5
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};  // trigger+ACK held
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};  // trigger ignored in BUS
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};

    #1;
    check_outs("reset0", 1'b0, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].rst, vecs[i].trig, vecs[i].ack);
      check_outs($sformatf("vec%0d", i), vecs[i].cyc, vecs[i].done, vecs[i].cnt, 1'b0);
    end

    // Reset mid-cycle: outputs drop without a clock edge
    step(1'b1, 1'b1, 1'b0);
    check_outs("midrst_pre", 1'b1, 1'b0, 4'd4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_outs("midrst_async", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_outs("midrst_after", 1'b0, 1'b0, 4'd0, 1'b0);

    // Back-to-back with ACK tied high, through counter wrap
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check_outs($sformatf("wrap%0d", i), (i % 3) == 0, (i % 3) == 1,
                 CNT_W'(((i + 2) / 3) % 16), 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    check_outs("wrap_idle", 1'b0, 1'b0, 4'd0, 1'b0);

`ifdef WB_NOP_TIMEOUT_EN
    // ACK on the expiry edge completes normally
    step(1'b1, 1'b1, 1'b0);
    check_outs("ackexp_bus0", 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_outs($sformatf("ackexp_bus%0d", i), 1'b1, 1'b0, 4'd0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    check_outs("ackexp_end", 1'b0, 1'b1, 4'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // No ACK: abort after 4 bus clocks
    step(1'b1, 1'b1, 1'b0);
    check_outs("tmo_bus0", 1'b1, 1'b0, 4'd1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_outs($sformatf("tmo_bus%0d", i), 1'b1, 1'b0, 4'd1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    check_outs("tmo_abort", 1'b0, 1'b0, 4'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check_outs("tmo_after", 1'b0, 1'b0, 4'd1, 1'b0);

    // Next trigger still works
    step(1'b1, 1'b1, 1'b0);
    check_outs("tmo_next_bus", 1'b1, 1'b0, 4'd1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_outs("tmo_next_end", 1'b0, 1'b1, 4'd2, 1'b0);
`else
    // Without the timeout option the bus phase waits indefinitely
    step(1'b1, 1'b1, 1'b0);
    check_outs("wait_bus0", 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_outs($sformatf("wait_bus%0d", i), 1'b1, 1'b0, 4'd0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    check_outs("wait_end", 1'b0, 1'b1, 4'd1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
